// File: rtl/seq_dividend_rebuilder_pkg.sv
// Shared types and constants for the sequential dividend rebuilder.
package seq_dividend_rebuilder_pkg;

    localparam int DR_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Bit-counter width: clog2 of the operand width, never below one bit.
    function automatic int cnt_width(input int w);
        int c;
        c = $clog2(w);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/seq_dividend_rebuilder.sv
// Sequential dividend rebuilder: A = Q*B + R via shift-and-add, one
// partial product per clock, start/busy/done handshake.
// Optional macro REM_CHECK_EN builds the remainder-invalid flag
// (err = R >= B); without it err is tied low.
module seq_dividend_rebuilder
    import seq_dividend_rebuilder_pkg::*;
#(
    parameter int WIDTH = DR_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     Q,
    input  logic [WIDTH-1:0]     B,
    input  logic [WIDTH-1:0]     R,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   A,
    output logic                 err
);

    localparam int CW = cnt_width(WIDTH);
    localparam int AW = 2 * WIDTH;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] q_lat;
    logic [WIDTH-1:0] b_lat;
    logic [WIDTH-1:0] r_lat;
    logic [AW-1:0]    acc;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last_step;
    logic [AW-1:0]    pp;
    logic [AW-1:0]    sum_r;

    assign accept    = (state == IDLE) && start;
    assign last_step = (cnt == CW'(WIDTH - 1));
    // Partial product for the current quotient bit; the result never
    // exceeds 2^(2W) - 2^W, so the 2W-bit accumulator cannot overflow.
    assign pp        = q_lat[cnt] ? ({{WIDTH{1'b0}}, b_lat} << cnt) : '0;
    assign sum_r     = acc + {{WIDTH{1'b0}}, r_lat};

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MUL;
            MUL:     if (last_step) state_nxt = ADD;
            ADD:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Operand capture on accepted start; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            q_lat <= Q;
            b_lat <= B;
            r_lat <= R;
        end
    end

    // Accumulator, bit counter and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            A   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                MUL: begin
                    acc <= acc + pp;
                    cnt <= cnt + CW'(1);
                end
                ADD: begin
                    acc <= sum_r;
                    A   <= sum_r;
                end
                default: ;
            endcase
        end
    end

`ifdef REM_CHECK_EN
    // Remainder-invalid flag: set at the ADD edge, cleared on a new start.
    always_ff @(posedge clk) begin
        if (rst)                 err <= 1'b0;
        else if (accept)         err <= 1'b0;
        else if (state == ADD)   err <= (r_lat >= b_lat);
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_dividend_rebuilder.sv
// Self-checking bench for seq_dividend_rebuilder: vector table plus
// hand-written timing, back-to-back and reset-abort sequences, results
// checked through a scoreboard queue.
module tb_seq_dividend_rebuilder;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   q;
    logic [W-1:0]   b;
    logic [W-1:0]   r;
    logic           busy;
    logic           done;
    logic [2*W-1:0] a;
    logic           err;

    typedef struct {
        logic [W-1:0]   q;
        logic [W-1:0]   b;
        logic [W-1:0]   r;
        logic [2*W-1:0] exp_a;
    } vec_t;

    typedef struct {
        logic [2*W-1:0] a;
        logic           err;
    } exp_t;

    exp_t sb[$];
    int   done_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    seq_dividend_rebuilder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .Q     (q),
        .B     (b),
        .R     (r),
        .busy  (busy),
        .done  (done),
        .A     (a),
        .err   (err)
    );

    function automatic logic exp_err(input logic [W-1:0] bb, input logic [W-1:0] rr);
`ifdef REM_CHECK_EN
        return (rr >= bb);
`else
        return 1'b0;
`endif
    endfunction

    function automatic exp_t model(input logic [W-1:0] qq, input logic [W-1:0] bb,
                                   input logic [W-1:0] rr);
        exp_t e;
        e.a   = {{W{1'b0}}, qq} * {{W{1'b0}}, bb} + {{W{1'b0}}, rr};
        e.err = exp_err(bb, rr);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            done_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                check("result_A", 32'(a), 32'(e.a));
                check("result_err", 32'(err), 32'(e.err));
            end
        end
    end

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("idle_seen", 32'(busy), 32'd0);
    endtask

    task automatic run_op(input logic [W-1:0] qq, input logic [W-1:0] bb,
                          input logic [W-1:0] rr, input logic [2*W-1:0] ea);
        exp_t e;
        wait_idle();
        e.a   = ea;
        e.err = exp_err(bb, rr);
        q = qq; b = bb; r = rr; start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   k;
        int   nd;

        vecs[0] = '{q: 4'd15, b: 4'd15, r: 4'd14, exp_a: 8'd239};
        vecs[1] = '{q: 4'd0,  b: 4'd0,  r: 4'd0,  exp_a: 8'd0};
        vecs[2] = '{q: 4'd2,  b: 4'd3,  r: 4'd5,  exp_a: 8'd11};
        vecs[3] = '{q: 4'd2,  b: 4'd3,  r: 4'd2,  exp_a: 8'd8};
        vecs[4] = '{q: 4'd1,  b: 4'd1,  r: 4'd0,  exp_a: 8'd1};
        vecs[5] = '{q: 4'd15, b: 4'd1,  r: 4'd0,  exp_a: 8'd15};
        vecs[6] = '{q: 4'd0,  b: 4'd15, r: 4'd15, exp_a: 8'd15};

        rst = 1'b1; start = 1'b0; q = '0; b = '0; r = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_A", 32'(a), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);

        // Basic timing: Q=3, B=4, R=1.
        q = 4'd3; b = 4'd4; r = 4'd1; start = 1'b1;
        sb.push_back(model(4'd3, 4'd4, 4'd1));
        @(negedge clk);
        start = 1'b0;
        check("busy_rise", 32'(busy), 32'd1);
        k = 1;
        while (done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("done_cycle", 32'(k), 32'd6);
        check("A_13", 32'(a), 32'd13);
        @(negedge clk);
        check("done_single_cycle", 32'(done), 32'd0);
        check("A_holds", 32'(a), 32'd13);

        // Table of operand vectors.
        for (int i = 0; i < 7; i++)
            run_op(vecs[i].q, vecs[i].b, vecs[i].r, vecs[i].exp_a);

        // Start held high with operands changing during MUL.
        wait_idle();
        q = 4'd5; b = 4'd6; r = 4'd2; start = 1'b1;
        sb.push_back(model(4'd5, 4'd6, 4'd2));
        @(negedge clk);
        q = 4'd9; b = 4'd7; r = 4'd3;
        sb.push_back(model(4'd9, 4'd7, 4'd3));
        @(negedge clk);
        q = 4'd1; b = 4'd1; r = 4'd1;
        @(negedge clk);
        q = 4'd9; b = 4'd7; r = 4'd3;
        wait_done();
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done();
        nd = done_cyc.size();
        if (nd >= 2)
            check("b2b_spacing", 32'(done_cyc[nd-1] - done_cyc[nd-2]), 32'd7);
        else
            check("b2b_done_count", 32'(nd), 32'd2);

        // Reset during the second MUL cycle aborts without a done.
        wait_idle();
        q = 4'd7; b = 4'd9; r = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_A", 32'(a), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        nd = done_cyc.size();
        repeat (10) @(negedge clk);
        check("abort_no_done", 32'(done_cyc.size()), 32'(nd));

        // rst and start on the same edge: reset wins.
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_over_start", 32'(busy), 32'd0);

        run_op(4'd7, 4'd9, 4'd1, 8'd64);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_dividend_rebuilder.md
# seq_dividend_rebuilder

- Sequential inverse of the combinational 4-bit divider. Reconstructs the dividend A = Q*B + R from a quotient, divisor and remainder using shift-and-add multiplication, one partial product per clock.
- Used as the checking end of the divider path: divider outputs plus the original divisor go in, and the rebuilt dividend is compared against the original A by the consumer.
- Start/busy/done handshake; one operation in flight at a time.

## Interface
- WIDTH, 4, operand width of Q, B, R; result is 2*WIDTH bits.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- Q  input  WIDTH  quotient; latched when start is accepted.
- B  input  WIDTH  divisor; latched when start is accepted.
- R  input  WIDTH  remainder; latched when start is accepted.
- busy  output  1  high in MUL, ADD, DONE.
- done  output  1  one-cycle pulse; A valid in that cycle.
- A  output  2*WIDTH  rebuilt dividend; holds until the next accepted start.
- err  output  1  remainder-invalid flag; see Configuration.

## Operation
- States: IDLE, MUL, ADD, DONE.
- IDLE:
  - On start=1, latch Q, B, R into internal registers.
  - Clear accumulator acc (2*WIDTH bits) and bit counter cnt (clog2(WIDTH) bits, minimum 1).
  - Go to MUL.
- MUL:
  - Each cycle: if latched Q[cnt]=1, acc += zero-extended B << cnt.
  - cnt increments.
  - After the step with cnt=WIDTH-1, go to ADD.
- ADD: acc += zero-extended R; A <= acc + R; go to DONE.
- DONE: done=1 for exactly this cycle; go to IDLE.
- Arithmetic is unsigned.
  - Maximum result is (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W, which always fits in 2*WIDTH bits, so there is no overflow and no carry out.
- B=0 or Q=0 gives A=R. No special case.
- start outside IDLE (MUL, ADD, DONE) is ignored. Inputs may change freely after acceptance.
- Reset values: state=IDLE, A=0, done=0, busy=0, err=0, acc=0, cnt=0.
- Reset asserted mid-operation aborts immediately on the next edge to the reset values. No done is produced.
- start and rst high on the same edge: rst wins.

## Timing
- Edge 0 samples start: IDLE->MUL.
- Edges 1..WIDTH: multiply steps.
- Edge WIDTH+1: ADD, A updated.
- done is high in the cycle following edge WIDTH+1 (6 cycles from start edge to done-visible for WIDTH=4, counting edge 0).
- Earliest next start is sampled at the edge that leaves DONE+1, i.e. in IDLE. Throughput is one result per WIDTH+3 cycles.
- A changes only at the ADD edge and on reset.

## Configuration
- REM_CHECK_EN defined:
  - At the ADD edge, err <= (R_latched >= B_latched), which covers B=0.
  - err is valid alongside done and holds with A.
  - err is cleared when start is accepted.
  - A is still computed normally.
- REM_CHECK_EN undefined: err is tied to 0 and the comparator is not built.

## Structure
- Package seq_dividend_rebuilder_pkg holds:
  - state typedef (enum IDLE, MUL, ADD, DONE);
  - default width constant DR_WIDTH=4;
  - helper function for counter width.
- Single module. The shift-add datapath is small, so no sub-module is warranted.

## Test plan
- Q=3, B=4, R=1, start pulse:
  - busy rises next cycle;
  - done pulses at the 6th cycle;
  - A=8'd13;
  - err=0.
- Q=15, B=15, R=14 -> A=8'd239 (worst-case magnitude), no truncation.
- Q=0, B=0, R=0 -> A=0, done pulses. With REM_CHECK_EN: err=1.
- With REM_CHECK_EN, Q=2, B=3, R=5 -> A=11, err=1. A following Q=2, B=3, R=2 -> A=8, err=0.
- Start held high continuously with new operands during MUL:
  - operands are ignored until IDLE;
  - first result uses the originally latched values;
  - back-to-back results are WIDTH+3 cycles apart.
- rst asserted in the second MUL cycle of Q=7, B=9, R=1:
  - next cycle state=IDLE, A=0, busy=0, done never pulses;
  - a fresh start afterwards gives A=64.
